prbs_link_test_ctrl: RTL
========================

# prbs_link_test_ctrl

Sequencer for the receive-side PRBS7 link test. It resets the word aligner and waits for alignment with a timeout and bounded retries. It then lets the link settle and runs a fixed-length bit-error measurement window, accumulating the per-word error-bit counts. It sits in the `gt0_rxusrclk2_i` domain between the transceiver RX path / aligner and the debug/status logic, and is the single owner of the aligner reset.

## Interface
Parameters:
- RST_CYCLES, 4: width of the aligner reset pulse, in cycles (≥1).
- ALIGN_TIMEOUT, 1024: cycles allowed in WAIT_ALIGN before a retry (≥2).
- SETTLE_CYCLES, 64: cycles `aligned` must stay high before measuring (≥1).
- WINDOW_LOG2, 20: measurement window is 2^WINDOW_LOG2 words (1..31).
- MAX_RETRY, 3: retries allowed after the first attempt (0..15).
- ERR_W, 32: width of the error-bit accumulator.

Ports:
- clk, in, 1: RX user clock, one word per cycle.
- reset, in, 1: asynchronous, active-high.
- start, in, 1: one-cycle request to begin a run.
- abort, in, 1: return to IDLE from any state.
- aligned, in, 1: aligner lock status.
- err_bits, in, 6: count of bit errors in the current word (0..32).
- aligner_rst, out, 1: reset to the word aligner.
- busy, out, 1: state is not IDLE, DONE or FAIL.
- measuring, out, 1: state is MEASURE.
- done, out, 1: run completed; level, held until the next start or abort.
- fail, out, 1: retries exhausted; level, held until the next start or abort.
- retry_cnt, out, 4: retries consumed in the current run.
- word_cnt, out, WINDOW_LOG2+1: words measured.
- err_total, out, ERR_W: accumulated error bits, saturating.
- state_o, out, 3: state encoding, for debug.

## Operation
States: IDLE=0, RST=1, WAIT_ALIGN=2, SETTLE=3, MEASURE=4, DONE=5, FAIL=6.

- **IDLE.** `start` → RST. Entering RST from IDLE, DONE or FAIL clears retry_cnt, word_cnt and err_total.
- **RST.** aligner_rst=1 for exactly RST_CYCLES cycles, then → WAIT_ALIGN.
- **WAIT_ALIGN.** `aligned`=1 → SETTLE. If the timer reaches ALIGN_TIMEOUT cycles without alignment, take the retry path.
- **SETTLE.** Counts SETTLE_CYCLES consecutive cycles. `aligned`=0 at any point takes the retry path. On reaching the count → MEASURE.
- **MEASURE.** Each cycle: word_cnt += 1; err_total += err_bits, saturating at all-ones. When word_cnt reaches 2^WINDOW_LOG2 → DONE. `aligned`=0 takes the retry path.
- **Retry path.**
  - If retry_cnt == MAX_RETRY → FAIL.
  - Otherwise retry_cnt += 1, clear word_cnt and err_total, → RST.
- **DONE / FAIL.** Results hold. `start` → RST.
- **Priority within one cycle:** abort > loss of `aligned` > window complete / timeout > start. In MEASURE, a loss on the final word takes the retry path, not DONE.
- `start` is ignored while busy.
- err_bits is sampled only in MEASURE. The value on the final window word is included in err_total.

## Timing
- All outputs are registered and decoded from registered state and counters.
- Reset values: all outputs 0; state IDLE.
- An asynchronous reset mid-run forces IDLE immediately and deasserts aligner_rst.
- `start` sampled at edge N: state=RST and aligner_rst=1 after edge N; aligner_rst is high for cycles N+1..N+RST_CYCLES.
- WAIT_ALIGN timeout: the retry decision is registered on the ALIGN_TIMEOUT-th cycle in WAIT_ALIGN.
- `aligned` high on the first WAIT_ALIGN cycle: state=SETTLE on the next cycle.
- MEASURE lasts exactly 2^WINDOW_LOG2 cycles. word_cnt=2^WINDOW_LOG2 and done=1 appear together on the first DONE cycle.
- abort: IDLE on the next cycle. aligner_rst deasserts and counters hold their last values (they are not cleared).

## Structure
- **Package `prbs_ctrl_pkg`:** state encoding constants (3-bit), the err_bits width (6), and the retry_cnt width (4).
- **Sub-module `prbs_ctrl_timer`:** one shared down-counter, loaded on each state entry with RST_CYCLES, ALIGN_TIMEOUT or SETTLE_CYCLES, with an `expired` output. It is reused by RST, WAIT_ALIGN and SETTLE.
- **FSM and accumulators:** live in the top module. The saturating adder is inline.

## Test plan
Bench parameters: RST_CYCLES=4, ALIGN_TIMEOUT=16, SETTLE_CYCLES=4, WINDOW_LOG2=4, MAX_RETRY=2.

1. **Clean run.** `start` with `aligned`=1 throughout and err_bits=0 → aligner_rst high for 4 cycles, MEASURE for 16 cycles, then done=1, word_cnt=16, err_total=0, retry_cnt=0.
2. **Error accumulation.** err_bits=3 on every MEASURE word → err_total=48. With ERR_W=5, the same stimulus saturates err_total at 31.
3. **Retries exhausted.** `aligned` held at 0 → three aligner_rst pulses, retry_cnt=2, then fail=1 after 3×(4+16) cycles plus transition cycles. A later `start` clears retry_cnt and restarts.
4. **Loss mid-measure.** `aligned` drops on MEASURE word 10 → word_cnt and err_total cleared, retry_cnt=1, state RST; a subsequent clean pass ends with done=1 and word_cnt=16.
5. **Simultaneous events.** `aligned` drops on the 16th word → retry path, not DONE. abort together with `start` in IDLE → stays IDLE. `start` during MEASURE → ignored.
6. **Async reset mid-run.** Assert `reset` during SETTLE → all outputs 0 without waiting for a clock edge, state=IDLE.

Source files
------------

// File: rtl/prbs_ctrl_pkg.sv
// Shared encodings and widths for the PRBS7 receive-side link test sequencer.
package prbs_ctrl_pkg;

    localparam int STATE_W    = 3;
    localparam int ERR_BITS_W = 6;
    localparam int RETRY_W    = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_RST        = 3'd1,
        ST_WAIT_ALIGN = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_MEASURE    = 3'd4,
        ST_DONE       = 3'd5,
        ST_FAIL       = 3'd6
    } state_e;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/prbs_ctrl_timer.sv
// Shared down-counter for the RST, WAIT_ALIGN and SETTLE phases; expired when it reaches zero.
module prbs_ctrl_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/prbs_link_test_ctrl.sv
// PRBS7 link test sequencer: aligner reset, alignment wait with retries, settle,
// then a fixed-length bit-error measurement window with a saturating accumulator.
module prbs_link_test_ctrl
    import prbs_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 4,
    parameter int ALIGN_TIMEOUT = 1024,
    parameter int SETTLE_CYCLES = 64,
    parameter int WINDOW_LOG2   = 20,
    parameter int MAX_RETRY     = 3,
    parameter int ERR_W         = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   aligned,
    input  logic [ERR_BITS_W-1:0]  err_bits,
    output logic                   aligner_rst,
    output logic                   busy,
    output logic                   measuring,
    output logic                   done,
    output logic                   fail,
    output logic [RETRY_W-1:0]     retry_cnt,
    output logic [WINDOW_LOG2:0]   word_cnt,
    output logic [ERR_W-1:0]       err_total,
    output logic [STATE_W-1:0]     state_o
);

    // Timer holds (phase length - 1) so that expired marks the last cycle of the phase.
    localparam int TMR_MAX = max_of3(RST_CYCLES, ALIGN_TIMEOUT, SETTLE_CYCLES) - 1;
    localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);
    localparam int SUM_W   = ((ERR_W > ERR_BITS_W) ? ERR_W : ERR_BITS_W) + 1;

    localparam logic [WINDOW_LOG2:0] WORD_LAST   = {1'b0, {WINDOW_LOG2{1'b1}}};
    localparam logic [WINDOW_LOG2:0] WORD_ONE    = (WINDOW_LOG2 + 1)'(1);
    localparam logic [RETRY_W-1:0]   RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0]   RETRY_ONE   = RETRY_W'(1);
    localparam logic [SUM_W-1:0]     ERR_MAX     = SUM_W'({ERR_W{1'b1}});

    state_e            state;
    state_e            state_nxt;
    logic              retry_path;
    logic              cnt_clr;
    logic              retry_clr;
    logic              retry_inc;
    logic              acc_en;
    logic              tmr_load;
    logic              tmr_expired;
    logic [TMR_W-1:0]  tmr_load_val;
    logic [SUM_W-1:0]  err_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        retry_path = 1'b0;
        cnt_clr    = 1'b0;
        retry_clr  = 1'b0;
        retry_inc  = 1'b0;
        acc_en     = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        state_nxt = ST_RST;
                        cnt_clr   = 1'b1;
                        retry_clr = 1'b1;
                    end
                end
                ST_RST: begin
                    if (tmr_expired) state_nxt = ST_WAIT_ALIGN;
                end
                ST_WAIT_ALIGN: begin
                    if (aligned)          state_nxt  = ST_SETTLE;
                    else if (tmr_expired) retry_path = 1'b1;
                end
                ST_SETTLE: begin
                    if (!aligned)         retry_path = 1'b1;
                    else if (tmr_expired) state_nxt  = ST_MEASURE;
                end
                ST_MEASURE: begin
                    // Loss of alignment outranks window completion, so the word is not counted.
                    if (!aligned) begin
                        retry_path = 1'b1;
                    end else begin
                        acc_en = 1'b1;
                        if (word_cnt == WORD_LAST) state_nxt = ST_DONE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
            if (retry_path) begin
                if (retry_cnt == RETRY_LIMIT) begin
                    state_nxt = ST_FAIL;
                end else begin
                    state_nxt = ST_RST;
                    retry_inc = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        tmr_load_val = '0;
        case (state_nxt)
            ST_RST:        tmr_load_val = TMR_W'(RST_CYCLES - 1);
            ST_WAIT_ALIGN: tmr_load_val = TMR_W'(ALIGN_TIMEOUT - 1);
            ST_SETTLE:     tmr_load_val = TMR_W'(SETTLE_CYCLES - 1);
            default:       tmr_load_val = '0;
        endcase
    end

    assign tmr_load = (state_nxt != state);

    prbs_ctrl_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expired  (tmr_expired)
    );

    assign err_sum = SUM_W'(err_total) + SUM_W'(err_bits);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_cnt <= '0;
            word_cnt  <= '0;
            err_total <= '0;
        end else begin
            if (retry_clr) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RETRY_ONE;
            end
            if (cnt_clr) begin
                word_cnt  <= '0;
                err_total <= '0;
            end else if (acc_en) begin
                word_cnt  <= word_cnt + WORD_ONE;
                err_total <= (err_sum > ERR_MAX) ? '1 : err_sum[ERR_W-1:0];
            end
        end
    end

    assign aligner_rst = (state == ST_RST);
    assign busy        = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_FAIL);
    assign measuring   = (state == ST_MEASURE);
    assign done        = (state == ST_DONE);
    assign fail        = (state == ST_FAIL);
    assign state_o     = state;

endmodule
